// File: rtl/target_memory.sv
// target_memory: byte-addressed memory target that sits behind target_port.
// Writes are committed into an internal array. A read returns one byte on
// target_data_out, and the target stays busy while target_port serialises it.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   bus_rw                         bus direction (1 write), sampled while IDLE
//   target_addr_in / _valid        address and its one-cycle strobe
//   target_data_in / _valid        write data and its strobe (with address)
//   target_rw                      direction reported to target_port
//   target_ready                   high only in IDLE
//   target_ack                     one-cycle completion pulse
//   target_data_out / _valid       read byte and its one-cycle launch pulse
//   err_overrun, err_range         sticky error flags
module target_memory #(
    parameter logic [15:0] ADDR_BASE      = 16'h0000,
    parameter int          MEM_ADDR_WIDTH = 11,
    parameter int          WRITE_LATENCY  = 1,
    parameter int          READ_LATENCY   = 2,
    parameter int          TX_HOLD        = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_rw,
    input  logic [15:0] target_addr_in,
    input  logic        target_addr_in_valid,
    input  logic [7:0]  target_data_in,
    input  logic        target_data_in_valid,
    output logic        target_rw,
    output logic        target_ready,
    output logic        target_ack,
    output logic [7:0]  target_data_out,
    output logic        target_data_out_valid,
    output logic        err_overrun,
    output logic        err_range
);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, WR_WAIT, RD_WAIT, RD_TX, ACK} state_t;

    logic [7:0]  mem [DEPTH];
    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] off_q;
    logic        in_range_q;
    logic [7:0]  wdata_q;
    logic        rw_q;

    logic [15:0] off_in;
    logic        in_range_in;
    logic        launch;
    logic [MEM_ADDR_WIDTH-1:0] launch_idx;
    logic        launch_ok;

    // Offset wraps in 16 bits, so addresses below the base land far out of range.
    assign off_in      = target_addr_in - ADDR_BASE;
    assign in_range_in = (off_in >> MEM_ADDR_WIDTH) == 16'd0;

    assign target_ready = (state == IDLE);
    assign target_rw    = (state == IDLE) ? bus_rw : rw_q;

    // Read data is registered, so it must be launched one edge before the
    // last RD_WAIT cycle; with a single-cycle latency that edge is the strobe.
    always_comb begin
        launch     = 1'b0;
        launch_idx = off_q[MEM_ADDR_WIDTH-1:0];
        launch_ok  = in_range_q;
        if (state == IDLE && target_addr_in_valid && !target_data_in_valid &&
            READ_LATENCY == 1) begin
            launch     = 1'b1;
            launch_idx = off_in[MEM_ADDR_WIDTH-1:0];
            launch_ok  = in_range_in;
        end else if (state == RD_WAIT && cnt == 4'd2) begin
            launch = 1'b1;
        end
    end

    // Array has no reset; a reset on the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (!rst && state == WR_WAIT && cnt == 4'd1 && in_range_q)
            mem[off_q[MEM_ADDR_WIDTH-1:0]] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            cnt                   <= 4'd0;
            off_q                 <= 16'd0;
            in_range_q            <= 1'b0;
            wdata_q               <= 8'h00;
            rw_q                  <= 1'b0;
            target_ack            <= 1'b0;
            target_data_out       <= 8'h00;
            target_data_out_valid <= 1'b0;
            err_overrun           <= 1'b0;
            err_range             <= 1'b0;
        end else begin
            target_ack            <= 1'b0;
            target_data_out_valid <= launch;
            if (launch) begin
                target_data_out <= launch_ok ? mem[launch_idx] : 8'hFF;
                if (!launch_ok)
                    err_range <= 1'b1;
            end
            if (state != IDLE && (target_addr_in_valid || target_data_in_valid))
                err_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (target_addr_in_valid) begin
                        off_q      <= off_in;
                        in_range_q <= in_range_in;
                        if (target_data_in_valid) begin
                            wdata_q <= target_data_in;
                            rw_q    <= 1'b1;
                            cnt     <= 4'(WRITE_LATENCY);
                            state   <= WR_WAIT;
                        end else begin
                            rw_q  <= 1'b0;
                            cnt   <= 4'(READ_LATENCY);
                            state <= RD_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (!in_range_q)
                            err_range <= 1'b1;
                        target_ack <= 1'b1;
                        state      <= ACK;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        cnt   <= 4'(TX_HOLD);
                        state <= RD_TX;
                    end
                end
                RD_TX: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        target_ack <= 1'b1;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    cnt   <= 4'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_target_memory.sv
module tb_target_memory;
    localparam logic [15:0] BASE = 16'h1000;
    localparam int MAW = 11, WL = 1, RL = 2, TXH = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic        bus_rw = 1'b0, av = 1'b0, dvi = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [7:0]  din = 8'h0;
    logic        rw, rdy, ack, dov, eo, er;
    logic [7:0]  dout;

    // parameter-sweep instance
    logic        bus_rw2 = 1'b0, av2 = 1'b0, dvi2 = 1'b0;
    logic [15:0] addr2 = 16'h0;
    logic [7:0]  din2 = 8'h0;
    logic        rw2, rdy2, ack2, dov2, eo2, er2;
    logic [7:0]  dout2;

    target_memory #(.ADDR_BASE(BASE), .MEM_ADDR_WIDTH(MAW), .WRITE_LATENCY(WL),
                    .READ_LATENCY(RL), .TX_HOLD(TXH)) dut (
        .clk(clk), .rst(rst), .bus_rw(bus_rw),
        .target_addr_in(addr), .target_addr_in_valid(av),
        .target_data_in(din), .target_data_in_valid(dvi),
        .target_rw(rw), .target_ready(rdy), .target_ack(ack),
        .target_data_out(dout), .target_data_out_valid(dov),
        .err_overrun(eo), .err_range(er));

    target_memory #(.ADDR_BASE(BASE), .MEM_ADDR_WIDTH(MAW), .WRITE_LATENCY(4),
                    .READ_LATENCY(7), .TX_HOLD(TXH)) dut2 (
        .clk(clk), .rst(rst), .bus_rw(bus_rw2),
        .target_addr_in(addr2), .target_addr_in_valid(av2),
        .target_data_in(din2), .target_data_in_valid(dvi2),
        .target_rw(rw2), .target_ready(rdy2), .target_ack(ack2),
        .target_data_out(dout2), .target_data_out_valid(dov2),
        .err_overrun(eo2), .err_range(er2));

    int n_vec = 0, n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---- transaction-level model: cycle numbers of each event, byte array ----
    bit          started = 1'b0;
    bit          m_active = 1'b0, m_wr, m_inr, idle_prev;
    int          m_ack_at, m_val_at, m_idx, off, prev;
    logic [7:0]  m_wd;
    logic [7:0]  mmem [0:2047];
    bit          e_ack = 1'b0, e_dv = 1'b0, e_er = 1'b0, e_eo = 1'b0;
    logic [7:0]  e_dout = 8'h00;

    always @(posedge clk) begin
        cyc++;
        e_ack = 1'b0;
        e_dv  = 1'b0;
        if (rst) begin
            started  = 1'b1;
            m_active = 1'b0;
            e_dout   = 8'h00;
            e_er     = 1'b0;
            e_eo     = 1'b0;
        end else if (started) begin
            prev      = cyc - 1;
            idle_prev = !(m_active && prev <= m_ack_at);
            if (av && idle_prev) begin
                off      = (int'(addr) - int'(BASE)) & 16'hFFFF;
                m_inr    = off < (1 << MAW);
                m_idx    = off % (1 << MAW);
                m_active = 1'b1;
                m_wr     = dvi;
                if (dvi) begin
                    m_wd     = din;
                    m_val_at = -1;
                    m_ack_at = prev + WL + 1;
                end else begin
                    m_val_at = prev + RL;
                    m_ack_at = m_val_at + TXH + 1;
                end
            end else if ((av || dvi) && !idle_prev) begin
                e_eo = 1'b1;
            end
            if (m_active && cyc == m_val_at) begin
                e_dv   = 1'b1;
                e_dout = m_inr ? mmem[m_idx] : 8'hFF;
                if (!m_inr) e_er = 1'b1;
            end
            if (m_active && cyc == m_ack_at) begin
                e_ack = 1'b1;
                if (m_wr) begin
                    if (m_inr) mmem[m_idx] = m_wd;
                    else       e_er = 1'b1;
                end
            end
        end
    end

    // ---- per-cycle compare, plus event recording for literal checks ----
    int last_ack = -100, last_dv = -100, last_ack2 = -100, last_dv2 = -100;
    int n_ack = 0, n_dv = 0;
    logic [7:0] last_dout = 8'h00, last_dout2 = 8'h00;
    bit busy;

    always @(negedge clk) begin
        if (started) begin
            busy = m_active && cyc <= m_ack_at;
            chk("ready", rdy, !busy);
            chk("rw", rw, busy ? m_wr : bus_rw);
            chk("ack", ack, e_ack);
            chk("data_out_valid", dov, e_dv);
            chk("data_out", dout, e_dout);
            chk("err_overrun", eo, e_eo);
            chk("err_range", er, e_er);
            if (ack) begin last_ack = cyc; n_ack++; end
            if (dov) begin last_dv = cyc; last_dout = dout; n_dv++; end
            if (ack2) last_ack2 = cyc;
            if (dov2) begin last_dv2 = cyc; last_dout2 = dout2; end
        end
    end

    // ---- stimulus ----
    int s;

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic wr);
        @(negedge clk); #1;
        av = 1'b1; addr = a; dvi = wr; din = d; bus_rw = wr;
        s = cyc;
        @(negedge clk); #1;
        av = 1'b0; dvi = 1'b0; bus_rw = 1'b0;
    endtask

    task automatic strobe2(input logic [15:0] a, input logic [7:0] d, input logic wr);
        @(negedge clk); #1;
        av2 = 1'b1; addr2 = a; dvi2 = wr; din2 = d; bus_rw2 = wr;
        s = cyc;
        @(negedge clk); #1;
        av2 = 1'b0; dvi2 = 1'b0; bus_rw2 = 1'b0;
    endtask

    int acks_before, dvs_before;

    initial begin
        rst = 1'b1;
        gap(3);
        rst = 1'b0;
        chk("rst ready", rdy, 1'b1);
        chk("rst ack", ack, 1'b0);
        chk("rst data_out", dout, 8'h00);
        chk("rst err", {eo, er}, 2'b00);

        // write after reset
        strobe(16'h1005, 8'hA5, 1'b1);
        chk("wr ready low", rdy, 1'b0);
        gap(4);
        chk("wr ack latency", last_ack - s, 2);
        chk("wr errs", {eo, er}, 2'b00);

        // read back
        strobe(16'h1005, 8'h00, 1'b0);
        gap(14);
        chk("rd valid latency", last_dv - s, 2);
        chk("rd data", last_dout, 8'hA5);
        chk("rd ack after valid", last_ack - last_dv, 10);

        // out of range
        strobe(16'h1000, 8'h5A, 1'b1);
        gap(4);
        strobe(16'h0FFF, 8'h00, 1'b0);
        gap(14);
        chk("oor rd data", last_dout, 8'hFF);
        chk("oor err_range", er, 1'b1);
        strobe(16'h1800, 8'h77, 1'b1);
        gap(4);
        chk("oor wr ack latency", last_ack - s, 2);
        strobe(16'h1000, 8'h00, 1'b0);
        gap(14);
        chk("offset0 unchanged", last_dout, 8'h5A);
        chk("err_range sticky", er, 1'b1);

        // overrun during RD_TX
        acks_before = n_ack; dvs_before = n_dv;
        strobe(16'h1005, 8'h00, 1'b0);
        gap(3);
        strobe(16'h1000, 8'h00, 1'b0);
        gap(20);
        chk("overrun flag", eo, 1'b1);
        chk("overrun ack timing", last_ack - s, 7);
        chk("overrun one ack", n_ack - acks_before, 1);
        chk("overrun one read", n_dv - dvs_before, 1);

        // reset mid-write
        strobe(16'h1010, 8'h11, 1'b1);
        gap(4);
        acks_before = n_ack;
        strobe(16'h1010, 8'h3C, 1'b1);
        rst = 1'b1;
        gap(1);
        rst = 1'b0;
        gap(4);
        chk("mid-rst no ack", n_ack - acks_before, 0);
        chk("mid-rst errs cleared", {eo, er}, 2'b00);
        strobe(16'h1010, 8'h00, 1'b0);
        gap(14);
        chk("mid-rst old byte", last_dout, 8'h11);

        // parameter sweep on second instance
        strobe2(16'h1020, 8'h42, 1'b1);
        gap(8);
        chk("sweep wr ack", last_ack2 - s, 5);
        strobe2(16'h1020, 8'h00, 1'b0);
        gap(20);
        chk("sweep rd valid", last_dv2 - s, 7);
        chk("sweep rd data", last_dout2, 8'h42);
        chk("sweep rd ack", last_ack2 - last_dv2, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
